// File: rtl/ddr_ui_arbiter.sv
// Two-client arbiter in front of the MIG user interface, with in-order read-tag routing.
// Define DDR_ARB_FIXED_PRIO_EN for fixed priority (client 0 wins); round-robin otherwise.
module ddr_ui_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int RD_OUTST = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init_calib_complete_i,
  input  logic                c0_valid_i,
  input  logic [2:0]          c0_cmd_i,
  input  logic [ADDR_W-1:0]   c0_addr_i,
  input  logic [DATA_W-1:0]   c0_wdata_i,
  output logic                c0_ready_o,
  output logic [DATA_W-1:0]   c0_rd_data_o,
  output logic                c0_rd_valid_o,
  input  logic                c1_valid_i,
  input  logic [2:0]          c1_cmd_i,
  input  logic [ADDR_W-1:0]   c1_addr_i,
  input  logic [DATA_W-1:0]   c1_wdata_i,
  output logic                c1_ready_o,
  output logic [DATA_W-1:0]   c1_rd_data_o,
  output logic                c1_rd_valid_o,
  input  logic                app_rdy_i,
  input  logic                app_wdf_rdy_i,
  input  logic [DATA_W-1:0]   app_rd_data_i,
  input  logic                app_rd_data_valid_i,
  input  logic                app_rd_data_end_i,
  output logic                app_en_o,
  output logic [2:0]          app_cmd_o,
  output logic [ADDR_W-1:0]   app_addr_o,
  output logic [DATA_W-1:0]   app_wdf_data_o,
  output logic                app_wdf_wren_o,
  output logic                app_wdf_end_o,
  output logic [DATA_W/8-1:0] app_wdf_mask_o,
  output logic                rd_underflow_err_o
);

  localparam int PTR_W = $clog2(RD_OUTST);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    WAIT_CAL = 2'd0,
    IDLE     = 2'd1,
    ISSUE    = 2'd2
  } state_t;

  state_t              state_q;
  logic [2:0]          cmd_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
`ifndef DDR_ARB_FIXED_PRIO_EN
  logic                last_q;
`endif

  logic                tag_q [RD_OUTST];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [1:0]          rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                err_q;

  logic c0_rd_s, c1_rd_s, full_s, empty_s, elig0_s, elig1_s;
  logic issue_rd_s, app_en_s, accept_s, grant_ok_s, sel1_s, grant_s;
  logic push_s, pop_s;
  logic unused_s;

  // Eligibility, arbitration, UI handshake and tag-FIFO bookkeeping.
  always_comb begin
    c0_rd_s    = (c0_cmd_i != 3'b000);
    c1_rd_s    = (c1_cmd_i != 3'b000);
    full_s     = (cnt_q == CNT_W'(RD_OUTST));
    empty_s    = (cnt_q == {CNT_W{1'b0}});
    elig0_s    = c0_valid_i & ~(c0_rd_s & full_s);
    elig1_s    = c1_valid_i & ~(c1_rd_s & full_s);
    issue_rd_s = (cmd_q != 3'b000);
    app_en_s   = (state_q == ISSUE) & (issue_rd_s | app_wdf_rdy_i);
    accept_s   = app_en_s & app_rdy_i;
    grant_ok_s = init_calib_complete_i & ((state_q == IDLE) | accept_s);
`ifdef DDR_ARB_FIXED_PRIO_EN
    sel1_s     = elig1_s & ~elig0_s;
`else
    sel1_s     = elig1_s & (~elig0_s | ~last_q);
`endif
    grant_s    = grant_ok_s & (elig0_s | elig1_s);
    push_s     = grant_s & (sel1_s ? c1_rd_s : c0_rd_s);
    // A push into an empty FIFO is not yet poppable this cycle.
    pop_s      = app_rd_data_valid_i & ~empty_s;
    cnt_d      = cnt_q;
    if (push_s & ~pop_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_s & ~push_s) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Control FSM and the command register held on the UI until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_CAL;
      cmd_q   <= 3'b000;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
`ifndef DDR_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        WAIT_CAL: if (init_calib_complete_i) state_q <= IDLE;
        IDLE, ISSUE: begin
          if (grant_s) begin
            state_q <= ISSUE;
          end else if (accept_s) begin
            state_q <= init_calib_complete_i ? IDLE : WAIT_CAL;
          end
        end
        default: state_q <= WAIT_CAL;
      endcase
      if (grant_s) begin
        cmd_q   <= sel1_s ? c1_cmd_i   : c0_cmd_i;
        addr_q  <= sel1_s ? c1_addr_i  : c0_addr_i;
        wdata_q <= sel1_s ? c1_wdata_i : c0_wdata_i;
`ifndef DDR_ARB_FIXED_PRIO_EN
        last_q  <= sel1_s;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) tag_q[wr_ptr_q] <= sel1_s;
  end

  // Registered read return, steered by the tag at the FIFO head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 2'b00;
      rd_data_q  <= {DATA_W{1'b0}};
      err_q      <= 1'b0;
    end else begin
      rd_valid_q[0] <= pop_s & ~tag_q[rd_ptr_q];
      rd_valid_q[1] <= pop_s & tag_q[rd_ptr_q];
      if (pop_s) rd_data_q <= app_rd_data_i;
      if (app_rd_data_valid_i & empty_s) err_q <= 1'b1;
    end
  end

  assign c0_ready_o         = grant_s & ~sel1_s;
  assign c1_ready_o         = grant_s & sel1_s;
  assign c0_rd_valid_o      = rd_valid_q[0];
  assign c1_rd_valid_o      = rd_valid_q[1];
  assign c0_rd_data_o       = rd_data_q;
  assign c1_rd_data_o       = rd_data_q;
  assign app_en_o           = app_en_s;
  assign app_cmd_o          = cmd_q;
  assign app_addr_o         = addr_q;
  assign app_wdf_data_o     = wdata_q;
  assign app_wdf_wren_o     = accept_s & ~issue_rd_s;
  assign app_wdf_end_o      = accept_s & ~issue_rd_s;
  assign app_wdf_mask_o     = {(DATA_W/8){1'b0}};
  assign rd_underflow_err_o = err_q;
  // Burst length yields one beat per read, so the end strobe carries no information.
  assign unused_s           = app_rd_data_end_i;

endmodule

// File: tb/tb_ddr_ui_arbiter.sv
// Randomized bench for ddr_ui_arbiter against a transaction-level reference model.
module tb_ddr_ui_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int RO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cal = 1'b0;
  logic c0_valid = 1'b0, c1_valid = 1'b0;
  logic [2:0] c0_cmd = 3'd0, c1_cmd = 3'd0;
  logic [AW-1:0] c0_addr = '0, c1_addr = '0;
  logic [DW-1:0] c0_wdata = '0, c1_wdata = '0;
  logic c0_ready, c1_ready, c0_rd_valid, c1_rd_valid;
  logic [DW-1:0] c0_rd_data, c1_rd_data;
  logic app_rdy = 1'b0, app_wdf_rdy = 1'b0;
  logic [DW-1:0] app_rd_data = '0;
  logic app_rd_data_valid = 1'b0, app_rd_data_end = 1'b0;
  logic app_en, app_wdf_wren, app_wdf_end, err;
  logic [2:0] app_cmd;
  logic [AW-1:0] app_addr;
  logic [DW-1:0] app_wdf_data;
  logic [DW/8-1:0] app_wdf_mask;

  ddr_ui_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_OUTST(RO)) dut (
    .clk(clk), .rst(rst), .init_calib_complete_i(cal),
    .c0_valid_i(c0_valid), .c0_cmd_i(c0_cmd), .c0_addr_i(c0_addr), .c0_wdata_i(c0_wdata),
    .c0_ready_o(c0_ready), .c0_rd_data_o(c0_rd_data), .c0_rd_valid_o(c0_rd_valid),
    .c1_valid_i(c1_valid), .c1_cmd_i(c1_cmd), .c1_addr_i(c1_addr), .c1_wdata_i(c1_wdata),
    .c1_ready_o(c1_ready), .c1_rd_data_o(c1_rd_data), .c1_rd_valid_o(c1_rd_valid),
    .app_rdy_i(app_rdy), .app_wdf_rdy_i(app_wdf_rdy), .app_rd_data_i(app_rd_data),
    .app_rd_data_valid_i(app_rd_data_valid), .app_rd_data_end_i(app_rd_data_end),
    .app_en_o(app_en), .app_cmd_o(app_cmd), .app_addr_o(app_addr), .app_wdf_data_o(app_wdf_data),
    .app_wdf_wren_o(app_wdf_wren), .app_wdf_end_o(app_wdf_end), .app_wdf_mask_o(app_wdf_mask),
    .rd_underflow_err_o(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: UI phase (0 calibrating, 1 idle, 2 issuing), last winner, latched command,
  // FIFO of read owners, and what the read-return outputs must show this cycle.
  int m_phase, m_last;
  logic [2:0] m_cmd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_rdd;
  int m_tags[$];
  bit m_err, m_rdv0, m_rdv1;

  // Pending client requests, held stable until consumed.
  bit pv[2];
  logic [2:0] pc[2];
  logic [AW-1:0] pa[2];
  logic [DW-1:0] pd[2];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_last = 1; m_cmd = 3'd0; m_addr = '0; m_wd = '0; m_rdd = '0;
    m_tags.delete(); m_err = 0; m_rdv0 = 0; m_rdv1 = 0;
    pv[0] = 0; pv[1] = 0;
  endtask

  task automatic eval();
    int w, t;
    bit is_rd, en, acc, can, full, e0, e1;
    #1;
    if (rst) model_reset();
    is_rd = (m_cmd != 3'd0);
    en    = (m_phase == 2) && (is_rd || app_wdf_rdy);
    acc   = en && app_rdy;
    can   = !rst && cal && (m_phase == 1 || acc);
    full  = (m_tags.size() == RO);
    e0    = c0_valid && !((c0_cmd != 3'd0) && full);
    e1    = c1_valid && !((c1_cmd != 3'd0) && full);
    w = -1;
    if (e0 && e1) begin
`ifdef DDR_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = (m_last == 0) ? 1 : 0;
`endif
    end else if (e0) w = 0;
    else if (e1) w = 1;
    if (!can) w = -1;

    chk("c0_ready", c0_ready, w == 0);
    chk("c1_ready", c1_ready, w == 1);
    chk("app_en", app_en, en);
    chk("wdf_wren", app_wdf_wren, acc && !is_rd);
    chk("wdf_end", app_wdf_end, acc && !is_rd);
    chk("app_cmd", app_cmd, m_cmd);
    chk("app_addr", app_addr, m_addr);
    chk("wdf_data", app_wdf_data, m_wd);
    chk("wdf_mask", app_wdf_mask, 0);
    chk("c0_rd_valid", c0_rd_valid, m_rdv0);
    chk("c1_rd_valid", c1_rd_valid, m_rdv1);
    if (m_rdv0) chk("c0_rd_data", c0_rd_data, m_rdd);
    if (m_rdv1) chk("c1_rd_data", c1_rd_data, m_rdd);
    if (rst) begin
      chk("rst_c0_rd_data", c0_rd_data, 0);
      chk("rst_c1_rd_data", c1_rd_data, 0);
    end
    chk("underflow_err", err, m_err);
    if (rst) return;

    m_rdv0 = 0; m_rdv1 = 0;
    if (app_rd_data_valid) begin
      if (m_tags.size() > 0) begin
        t = m_tags.pop_front();
        if (t == 0) m_rdv0 = 1; else m_rdv1 = 1;
        m_rdd = app_rd_data;
      end else m_err = 1;
    end
    if (w >= 0) begin
      m_cmd = pc[w]; m_addr = pa[w]; m_wd = pd[w];
      if (pc[w] != 3'd0) m_tags.push_back(w);
      m_last = w; m_phase = 2; pv[w] = 0;
    end else if (m_phase == 2 && acc) m_phase = cal ? 1 : 0;
    else if (m_phase == 0 && cal) m_phase = 1;
  endtask

  // mode 0: random commands; 1: c0 writes, c1 reads; 2: no new requests.
  task automatic cycle(input int p_req, input int p_rdy, input int p_wdf, input int p_ret,
                       input int p_cal_lo, input int mode, input bit force_rdv, input bit do_rst);
    @(negedge clk);
    rst = do_rst;
    for (int i = 0; i < 2; i++) begin
      if (!pv[i] && mode != 2 && $urandom_range(99) < p_req) begin
        pv[i] = 1;
        if (mode == 1) pc[i] = (i == 0) ? 3'd0 : 3'd1;
        else pc[i] = ($urandom_range(1) == 0) ? 3'd0 : 3'($urandom_range(7, 1));
        pa[i] = $urandom;
        pd[i] = {$urandom, $urandom};
      end
    end
    c0_valid = pv[0]; c0_cmd = pc[0]; c0_addr = pa[0]; c0_wdata = pd[0];
    c1_valid = pv[1]; c1_cmd = pc[1]; c1_addr = pa[1]; c1_wdata = pd[1];
    app_rdy     = $urandom_range(99) < p_rdy;
    app_wdf_rdy = $urandom_range(99) < p_wdf;
    cal         = !($urandom_range(99) < p_cal_lo);
    app_rd_data_valid = force_rdv || (m_tags.size() > 0 && $urandom_range(99) < p_ret);
    app_rd_data_end   = app_rd_data_valid;
    app_rd_data       = {$urandom, $urandom};
    eval();
  endtask

  initial begin
    pc[0] = 3'd0; pc[1] = 3'd0; pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0;
    model_reset();
    repeat (2) cycle(0, 0, 0, 0, 100, 2, 1'b0, 1'b1);
    // Calibration held low with requests pending, then raised.
    repeat (5) cycle(100, 100, 100, 0, 100, 1, 1'b0, 1'b0);
    repeat (6) cycle(100, 100, 100, 0, 0, 1, 1'b0, 1'b0);
    // Contention with writes and reads, full rate.
    repeat (40) cycle(100, 100, 100, 50, 0, 0, 1'b0, 1'b0);
    // General random traffic with backpressure and calibration dips.
    repeat (300) cycle(60, 70, 60, 40, 3, 0, 1'b0, 1'b0);
    // Fill the read tag FIFO: no returns, c0 writes keep flowing.
    repeat (80) cycle(100, 100, 100, 0, 0, 1, 1'b0, 1'b0);
    repeat (300) cycle(70, 80, 70, 30, 2, 0, 1'b0, 1'b0);
    // Reset mid-operation discards outstanding reads.
    cycle(50, 100, 100, 0, 0, 0, 1'b0, 1'b1);
    repeat (150) cycle(80, 90, 80, 20, 0, 0, 1'b0, 1'b0);
    // Drain everything, then a read beat with nothing outstanding.
    repeat (80) cycle(0, 100, 100, 100, 0, 2, 1'b0, 1'b0);
    cycle(0, 100, 100, 0, 0, 2, 1'b1, 1'b0);
    repeat (5) cycle(0, 100, 100, 0, 0, 2, 1'b0, 1'b0);
    cycle(0, 100, 100, 0, 0, 2, 1'b0, 1'b1);
    repeat (40) cycle(60, 80, 80, 40, 0, 0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ddr_ui_arbiter.md
# ddr_ui_arbiter

Two-client arbiter sitting between DDR3 traffic sources and the MIG user interface (UI). It grants one client at a time onto the single app_* command/write-data port, using round-robin or fixed priority, and holds each command until the UI accepts it. It records the client ID of every read in an in-order tag FIFO and routes each app_rd_data beat back to the client that issued the read. Sits directly above the MIG, replacing single-master drivers.

## Interface
- ADDR_W, 32, address width of app_addr and client addresses
- DATA_W, 64, width of write and read data
- RD_OUTST, 16, maximum outstanding reads; depth of the tag FIFO (power of 2)
- clk  in  1  UI clock
- rst  in  1  reset, asynchronous, active-high
- init_calib_complete  in  1  MIG calibration done
- cN_valid  in  1  client N request (N = 0, 1)
- cN_cmd  in  3  000 = write, 001 = read; other codes are treated as read
- cN_addr  in  ADDR_W  request address
- cN_wdata  in  DATA_W  write data, ignored for reads
- cN_ready  out  1  request consumed at this edge
- cN_rd_data  out  DATA_W  returned read data
- cN_rd_valid  out  1  cN_rd_data valid, one beat per read
- app_rdy, app_wdf_rdy  in  1  MIG command-ready and write-FIFO-ready
- app_rd_data  in  DATA_W  MIG read data
- app_rd_data_valid, app_rd_data_end  in  1  MIG read-data strobes
- app_en  out  1  command valid
- app_cmd  out  3  command
- app_addr  out  ADDR_W  command address
- app_wdf_data  out  DATA_W  write data
- app_wdf_wren, app_wdf_end  out  1  write-data strobes
- app_wdf_mask  out  DATA_W/8  write mask, constant 0
- rd_underflow_err  out  1  sticky error flag

## Operation
- FSM states:
  - WAIT_CAL: entered on reset; moves to IDLE when init_calib_complete = 1.
  - IDLE: performs arbitration.
  - ISSUE: holds the latched command on app_* until it is accepted.
- Eligibility:
  - A client is eligible if cN_valid = 1.
  - An eligible read is additionally blocked while the tag-FIFO count equals RD_OUTST.
- Grant:
  - In IDLE, or in ISSUE on the accept cycle, with init_calib_complete = 1, pick one eligible client.
  - cN_ready = 1 combinationally in the grant cycle.
  - Latch cmd, addr and wdata into the command register.
  - If the granted command is a read, push N into the tag FIFO.
  - Go to (or stay in) ISSUE.
- Round-robin: when both clients are eligible, grant the client not granted last. The last-grant register resets to 1, so client 0 wins first.
- Outputs in ISSUE:
  - app_en = cmd_is_read | app_wdf_rdy.
  - Accept = app_en & app_rdy.
  - app_wdf_wren = app_wdf_end = accept & write.
- On accept with no eligible client, return to IDLE. If init_calib_complete = 0, go to WAIT_CAL instead.
- Calibration loss: an in-flight ISSUE completes normally; no new grant is made until calibration returns.
- Read return:
  - On app_rd_data_valid, pop the FIFO head T.
  - Next cycle: cT_rd_valid = 1 and cT_rd_data = the registered app_rd_data. The other client's rd_valid stays 0.
- Underflow: if app_rd_data_valid = 1 while the FIFO is empty, set rd_underflow_err (sticky until reset) and drop the beat.
- Simultaneous FIFO push and pop: the count is unchanged, and a push into an empty FIFO is not visible to a pop in the same cycle.

## Timing
- Reset values:
  - FSM = WAIT_CAL; FIFO empty.
  - app_en = 0, app_cmd = 0, app_addr = 0, app_wdf_data = 0.
  - cN_ready = 0, cN_rd_valid = 0, cN_rd_data = 0.
  - rd_underflow_err = 0.
- Grant-to-app_en latency: 1 cycle.
- With app_rdy held high, back-to-back grants sustain 1 command per cycle.
- Read-data return latency: 1 cycle after app_rd_data_valid.
- Reset asserted mid-operation: all state and outputs clear immediately; outstanding reads are discarded.
- app_rd_data_end is not used for routing (burst length gives 1 beat per command at DATA_W).

## Configuration
- DDR_ARB_FIXED_PRIO_EN:
  - Defined: client 0 always wins when both clients are eligible, and the last-grant register is unused.
  - Undefined: round-robin as described in Operation.

## Test plan
- Calibration hold: init_calib_complete = 0 with c0 writes pending -> no app_en and c0_ready = 0. Raise calibration -> app_en = 1 two cycles later.
- Contention: c0 and c1 each post 4 writes, app_rdy = app_wdf_rdy = 1 -> grant order 0,1,0,1,0,1,0,1; data at app_wdf_data matches per client; app_wdf_wren count = 8.
- Backpressure: app_wdf_rdy = 0 for 5 cycles during a write -> app_en = 0 and addr/data stable; the command issues in the cycle app_wdf_rdy returns.
- Read routing: c0 reads addr 0x00, c1 reads 0x08, c0 reads 0x10; three read beats returned -> c0, c1, c0 rd_valid in that order, 1 cycle after each app_rd_data_valid.
- Outstanding limit: 16 reads from c1 with no returns -> 17th read not granted while a c0 write is still granted. One return -> the 17th read is granted.
- Underflow: app_rd_data_valid pulse with an empty FIFO -> rd_underflow_err = 1 until rst; no cN_rd_valid.
